fe_fetch_unit: RTL and testbench
================================

FE_FETCH_UNIT -- requirements
Module: fe_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 Parameter PC_STEP, 4, sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 imem_req_o  output  1  instruction memory request valid.
REQ-006 imem_addr_o  output  32  request address; always equals current PC.
REQ-007 imem_gnt_i  input  1  memory accepts request this cycle when sampled with imem_req_o=1.
REQ-008 imem_rvalid_i  input  1  response data valid; exactly one response per grant, one or more cycles after the grant.
REQ-009 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-010 redirect_i  input  1  control-flow redirect (branch/jump/trap) from downstream stage.
REQ-011 redirect_pc_i  input  32  redirect target.
REQ-012 if_valid_o  output  1  fetched instruction available to decode.
REQ-013 if_ready_i  input  1  decode accepts the instruction; transfer occurs when if_valid_o and if_ready_i are both 1.
REQ-014 if_instr_o  output  32  registered instruction word.
REQ-015 if_pc_o  output  32  address of if_instr_o.
REQ-016 if_pc_next_o  output  32  if_pc_o + PC_STEP.
REQ-017 if_illegal_o  output  1  instr[1:0] != 2'b11 or instr[6:0] not one of the ten RV32I opcodes (R, I, LOAD, JALR, ENV, S, B, J, LUI, AUIPC).
REQ-018 fetch_cnt_o  output  32  count of completed decode handshakes.

Function
REQ-019 The block SHALL implement FSM states RST_S, REQ_S, WAIT_S, OUT_S, DRAIN_S.
REQ-020 RST_S SHALL last exactly one cycle after reset release, then go to REQ_S.
REQ-021 REQ_S: imem_req_o=1; on imem_gnt_i go to WAIT_S, otherwise stay with imem_addr_o stable.
REQ-022 WAIT_S: imem_req_o=0; on imem_rvalid_i capture imem_rdata_i into if_instr_o, current PC into if_pc_o, PC+PC_STEP into if_pc_next_o and the PC, compute if_illegal_o from captured word, go to OUT_S.
REQ-023 OUT_S: if_valid_o=1 with all if_* outputs stable; on if_ready_i go to REQ_S and increment fetch_cnt_o by 1 (wraps 32'hFFFF_FFFF -> 0).
REQ-024 if_valid_o SHALL be 1 only in OUT_S; imem_req_o only in REQ_S.
REQ-025 Minimum latency: request-to-valid 2 cycles with same-cycle grant and next-cycle rvalid; sustained rate 1 instruction per 3 cycles.
REQ-026 Redirect SHALL have priority over every other event and load PC with {redirect_pc_i[31:2], 2'b00}.
REQ-027 Redirect in REQ_S without grant: stay in REQ_S; imem_addr_o shows new PC next cycle.
REQ-028 Redirect in REQ_S with grant same cycle: go to DRAIN_S.
REQ-029 Redirect in WAIT_S without rvalid: go to DRAIN_S; with rvalid same cycle: discard data, go to REQ_S.
REQ-030 DRAIN_S: imem_req_o=0, if_valid_o=0; on imem_rvalid_i discard data and go to REQ_S; redirect in DRAIN_S updates PC only.
REQ-031 Redirect in OUT_S: drop if_valid_o next cycle, go to REQ_S, no fetch_cnt_o increment even if if_ready_i=1 same cycle.
REQ-032 Discarded responses SHALL never alter if_instr_o, if_pc_o, if_illegal_o or fetch_cnt_o.
REQ-033 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-034 imem_rvalid_i outside WAIT_S/DRAIN_S SHALL be ignored.

Reset
REQ-035 With rst_n=0 at a rising edge: state=RST_S, PC=RESET_PC, imem_req_o=0, if_valid_o=0, if_instr_o=32'h0000_0013 (NOP), if_pc_o=RESET_PC, if_pc_next_o=RESET_PC+4, if_illegal_o=0, fetch_cnt_o=0.
REQ-036 Reset asserted in any state, including WAIT_S/DRAIN_S with a response outstanding, SHALL take effect at the next edge; a stale rvalid arriving in RST_S is ignored.

Verification
REQ-037 Reset release, gnt=1 always, rvalid 1 cycle after grant, rdata=32'h0000_0093, ready=1 -> first if_valid_o at cycle 3 with if_pc_o=32'h0040_0000, second with 32'h0040_0004, fetch_cnt_o=2.
REQ-038 gnt held 0 for 5 cycles -> imem_req_o=1 and imem_addr_o=32'h0040_0000 stable all 5 cycles, no valid.
REQ-039 ready=0 for 4 cycles in OUT_S -> if_instr_o/if_pc_o unchanged, no new request, fetch_cnt_o unchanged.
REQ-040 Redirect to 32'h0040_0102 in WAIT_S, response 3 cycles later -> response discarded, next request address 32'h0040_0100.
REQ-041 rdata=32'h0000_0000 -> if_illegal_o=1; rdata=32'h0000_006F (JAL) -> if_illegal_o=0.
REQ-042 PC at 32'hFFFF_FFFC, one handshake -> if_pc_next_o=0, next request address 0.

Source files
------------

// File: rtl/fe_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request at a time, a single
// registered output slot toward decode, and redirect handling that discards
// any response belonging to the abandoned control-flow path.
module fe_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc_next_o,
   output logic        if_illegal_o,
   output logic [31:0] fetch_cnt_o
);

   localparam logic [31:0] STEP = 32'(PC_STEP);
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [2:0] {RST_S, REQ_S, WAIT_S, OUT_S, DRAIN_S} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc_next_q, if_pc_next_d;
   logic        illegal_q, illegal_d;
   logic [31:0] cnt_q, cnt_d;

   // Every valid RV32I base opcode ends in 2'b11, so a word whose low bits
   // are not 2'b11 falls through to the default and is flagged as well.
   function automatic logic is_illegal(input logic [31:0] w);
      case (w[6:0])
         7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
         7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111:
            is_illegal = 1'b0;
         default:
            is_illegal = 1'b1;
      endcase
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its inputs regardless of block order.
      if (!rst_n) state_q <= RST_S;
      else        state_q <= state_d;
   end

   // Next-state logic; a redirect always wins and any response in flight at
   // that moment is routed through DRAIN_S so it can never reach decode.
   always_comb begin
      // NOTE: the default at the top of a combinational block keeps every
      // path assigned, so no latch is inferred.
      state_d = state_q;
      case (state_q)
         RST_S:   state_d = REQ_S;
         REQ_S: begin
            if (redirect_i)      state_d = imem_gnt_i ? DRAIN_S : REQ_S;
            else if (imem_gnt_i) state_d = WAIT_S;
         end
         WAIT_S: begin
            if (redirect_i)         state_d = imem_rvalid_i ? REQ_S : DRAIN_S;
            else if (imem_rvalid_i) state_d = OUT_S;
         end
         OUT_S: begin
            if (redirect_i || if_ready_i) state_d = REQ_S;
         end
         DRAIN_S: begin
            if (imem_rvalid_i) state_d = REQ_S;
         end
         default: state_d = RST_S;
      endcase
   end

   // Datapath next values: capture on a kept response, count on handshake.
   always_comb begin
      pc_d         = pc_q;
      instr_d      = instr_q;
      if_pc_d      = if_pc_q;
      if_pc_next_d = if_pc_next_q;
      illegal_d    = illegal_q;
      cnt_d        = cnt_q;
      if (state_q == WAIT_S && imem_rvalid_i && !redirect_i) begin
         instr_d      = imem_rdata_i;
         if_pc_d      = pc_q;
         if_pc_next_d = pc_q + STEP;
         illegal_d    = is_illegal(imem_rdata_i);
         pc_d         = pc_q + STEP;
      end
      if (state_q == OUT_S && if_ready_i && !redirect_i) cnt_d = cnt_q + 32'd1;
      if (redirect_i) pc_d = {redirect_pc_i[31:2], 2'b00};
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      // NOTE: these are plain flops, not a memory array, so all of them get a
      // defined reset value and decode sees a NOP at a known PC.
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         instr_q      <= NOP;
         if_pc_q      <= RESET_PC;
         if_pc_next_q <= RESET_PC + STEP;
         illegal_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         if_pc_q      <= if_pc_d;
         if_pc_next_q <= if_pc_next_d;
         illegal_q    <= illegal_d;
         cnt_q        <= cnt_d;
      end
   end

   // Outputs decoded from the current state plus registered datapath values.
   always_comb begin
      imem_req_o   = (state_q == REQ_S);
      if_valid_o   = (state_q == OUT_S);
      imem_addr_o  = pc_q;
      if_instr_o   = instr_q;
      if_pc_o      = if_pc_q;
      if_pc_next_o = if_pc_next_q;
      if_illegal_o = illegal_q;
      fetch_cnt_o  = cnt_q;
   end

endmodule

// File: tb/tb_fe_fetch_unit.sv
// Directed bench for fe_fetch_unit: inputs change 1 ns after each rising
// edge and outputs are compared at that same point.
module tb_fe_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_pc_next_o;
   logic        if_illegal_o;
   logic [31:0] fetch_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   fe_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_valid_o    (if_valid_o),
      .if_ready_i    (if_ready_i),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_pc_next_o  (if_pc_next_o),
      .if_illegal_o  (if_illegal_o),
      .fetch_cnt_o   (fetch_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFF;
      redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
      tick(); tick();

      // Reset values, with a stray rvalid present during reset.
      check1("rst_req",     imem_req_o,   1'b0);
      check1("rst_valid",   if_valid_o,   1'b0);
      check ("rst_addr",    imem_addr_o,  32'h0040_0000);
      check ("rst_instr",   if_instr_o,   32'h0000_0013);
      check ("rst_pc",      if_pc_o,      32'h0040_0000);
      check ("rst_pc_next", if_pc_next_o, 32'h0040_0004);
      check1("rst_illegal", if_illegal_o, 1'b0);
      check ("rst_cnt",     fetch_cnt_o,  32'd0);

      // Release with stale rvalid in RST_S, then gnt held low for 5 cycles.
      rst_n = 1'b1;
      check1("rst_s_req", imem_req_o, 1'b0);
      tick();
      imem_rvalid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check1("stall_req",   imem_req_o,  1'b1);
         check ("stall_addr",  imem_addr_o, 32'h0040_0000);
         check1("stall_valid", if_valid_o,  1'b0);
         tick();
      end
      check("stale_instr", if_instr_o, 32'h0000_0013);

      // Reset asserted in WAIT_S with a response arriving on the reset edge.
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0; rst_n = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0000;
      tick();
      imem_rvalid_i = 1'b0;
      check1("wrst_req",   imem_req_o,  1'b0);
      check1("wrst_valid", if_valid_o,  1'b0);
      check ("wrst_instr", if_instr_o,  32'h0000_0013);

      // Back-to-back fetches: valid at cycle 3 after release.
      rst_n = 1'b1; imem_gnt_i = 1'b1; imem_rdata_i = 32'h0000_0093; if_ready_i = 1'b1;
      tick();
      check1("c1_req",  imem_req_o,  1'b1);
      check ("c1_addr", imem_addr_o, 32'h0040_0000);
      tick();
      check1("c2_req",   imem_req_o, 1'b0);
      check1("c2_valid", if_valid_o, 1'b0);
      imem_rvalid_i = 1'b1;
      tick();
      imem_rvalid_i = 1'b0;
      check1("c3_valid",   if_valid_o,   1'b1);
      check ("c3_pc",      if_pc_o,      32'h0040_0000);
      check ("c3_instr",   if_instr_o,   32'h0000_0093);
      check ("c3_pc_next", if_pc_next_o, 32'h0040_0004);
      check1("c3_illegal", if_illegal_o, 1'b0);
      tick();
      check ("c4_cnt",   fetch_cnt_o, 32'd1);
      check1("c4_valid", if_valid_o,  1'b0);
      check ("c4_addr",  imem_addr_o, 32'h0040_0004);
      tick();
      imem_rvalid_i = 1'b1;
      tick();
      imem_rvalid_i = 1'b0;
      check1("f2_valid", if_valid_o, 1'b1);
      check ("f2_pc",    if_pc_o,    32'h0040_0004);
      tick();
      check("f2_cnt",  fetch_cnt_o, 32'd2);
      check("f2_addr", imem_addr_o, 32'h0040_0008);

      // Illegal all-zero word, decode stalls for 4 cycles.
      imem_rdata_i = 32'h0000_0000; if_ready_i = 1'b0;
      tick();
      imem_rvalid_i = 1'b1;
      tick();
      imem_rvalid_i = 1'b0;
      check1("zero_illegal", if_illegal_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check1("hold_valid", if_valid_o,  1'b1);
         check ("hold_instr", if_instr_o,  32'h0000_0000);
         check ("hold_pc",    if_pc_o,     32'h0040_0008);
         check1("hold_req",   imem_req_o,  1'b0);
         check ("hold_cnt",   fetch_cnt_o, 32'd2);
      end
      if_ready_i = 1'b1;
      tick();
      check("hold_done_cnt",  fetch_cnt_o, 32'd3);
      check("hold_done_addr", imem_addr_o, 32'h0040_000C);

      // JAL is legal.
      imem_rdata_i = 32'h0000_006F;
      tick();
      imem_rvalid_i = 1'b1;
      tick();
      imem_rvalid_i = 1'b0;
      check1("jal_illegal", if_illegal_o, 1'b0);
      check ("jal_instr",   if_instr_o,   32'h0000_006F);
      check ("jal_pc",      if_pc_o,      32'h0040_000C);
      tick();
      check("jal_cnt", fetch_cnt_o, 32'd4);

      // Redirect in WAIT_S, response 3 cycles later is discarded.
      tick();
      redirect_i = 1'b1; redirect_pc_i = 32'h0040_0102;
      tick();
      redirect_i = 1'b0;
      check1("drain_req",   imem_req_o,  1'b0);
      check1("drain_valid", if_valid_o,  1'b0);
      check ("drain_addr",  imem_addr_o, 32'h0040_0100);
      tick();
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hFFFF_FFFF;
      tick();
      imem_rvalid_i = 1'b0;
      check1("rd_req",     imem_req_o,   1'b1);
      check ("rd_addr",    imem_addr_o,  32'h0040_0100);
      check ("rd_instr",   if_instr_o,   32'h0000_006F);
      check ("rd_pc",      if_pc_o,      32'h0040_000C);
      check ("rd_cnt",     fetch_cnt_o,  32'd4);
      check1("rd_illegal", if_illegal_o, 1'b0);

      // Redirect in REQ_S without grant, to the top of the address space.
      imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
      tick();
      redirect_i = 1'b0; imem_gnt_i = 1'b1;
      check1("rq_req",  imem_req_o,  1'b1);
      check ("rq_addr", imem_addr_o, 32'hFFFF_FFFC);
      tick();
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
      tick();
      imem_rvalid_i = 1'b0;
      check("wrap_pc",      if_pc_o,      32'hFFFF_FFFC);
      check("wrap_pc_next", if_pc_next_o, 32'h0000_0000);
      tick();
      check("wrap_addr", imem_addr_o, 32'h0000_0000);
      check("wrap_cnt",  fetch_cnt_o, 32'd5);

      // Redirect in REQ_S with grant goes through DRAIN_S.
      redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
      tick();
      redirect_i = 1'b0;
      check1("rg_req",  imem_req_o,  1'b0);
      check ("rg_addr", imem_addr_o, 32'h0040_0200);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0000;
      tick();
      imem_rvalid_i = 1'b0;
      check1("rg2_req",   imem_req_o,  1'b1);
      check ("rg2_instr", if_instr_o,  32'h0000_0013);

      // Redirect in OUT_S with ready: no handshake counted.
      imem_rdata_i = 32'h0000_0033;
      tick();
      imem_rvalid_i = 1'b1;
      tick();
      imem_rvalid_i = 1'b0;
      check1("ro_valid", if_valid_o, 1'b1);
      check ("ro_pc",    if_pc_o,    32'h0040_0200);
      redirect_i = 1'b1; redirect_pc_i = 32'h0040_0300;
      tick();
      redirect_i = 1'b0;
      check1("ro2_valid", if_valid_o,  1'b0);
      check ("ro2_cnt",   fetch_cnt_o, 32'd5);
      check ("ro2_addr",  imem_addr_o, 32'h0040_0300);

      // Redirect in WAIT_S with rvalid in the same cycle: back to REQ_S.
      tick();
      redirect_i = 1'b1; redirect_pc_i = 32'h0040_0400; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0000;
      tick();
      redirect_i = 1'b0; imem_rvalid_i = 1'b0;
      check1("rw_req",   imem_req_o,  1'b1);
      check ("rw_addr",  imem_addr_o, 32'h0040_0400);
      check ("rw_instr", if_instr_o,  32'h0000_0033);
      check ("rw_pc",    if_pc_o,     32'h0040_0200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
